// File: rtl/nubus_master.sv
// NuBus initiator: arbitrates, drives START/address/TM, waits for ACK, retries on try-again-later.
// Latency: request to rsp_done is at least 5 cycles; local side is stalled (req_ready=0) outside IDLE.
module nubus_master #(
    parameter int TIMEOUT   = 255,
    parameter int RETRY_MAX = 3
) (
    input  logic        nub_clkn,
    input  logic        nub_reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [29:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_done,
    output logic [1:0]  rsp_status,
    output logic [31:0] rsp_rdata,
    input  logic        arb_grant,
    output logic        nub_rqstn_o,
    input  logic        nub_startn,
    input  logic        nub_ackn,
    input  logic        nub_tm1n,
    input  logic        nub_tm0n,
    output logic        nub_startn_o,
    output logic        nub_tm1n_o,
    output logic        nub_tm0n_o,
    input  logic [31:0] nub_ad_i,
    output logic [31:0] nub_ad_o,
    output logic        nub_ad_oe,
    output logic        mstdn
);

    typedef enum logic [2:0] {S_IDLE, S_ARB, S_ADDR, S_DATA, S_DONE} state_t;

    localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);
    localparam logic [3:0] RMAX  = 4'(RETRY_MAX);

    state_t      state_q, state_d;
    logic        wr_q, wr_d;
    logic [29:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  tcnt_q, tcnt_d;
    logic [3:0]  rcnt_q, rcnt_d;
    logic        retry_q, retry_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_done_q, rsp_done_d;
    logic [1:0]  rsp_status_q, rsp_status_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rqstn_q, rqstn_d;
    logic        startn_q, startn_d;
    logic        tm1n_q, tm1n_d;
    logic        tm0n_q, tm0n_d;
    logic [31:0] ad_q, ad_d;
    logic        oe_q, oe_d;
    logic        mstdn_q, mstdn_d;
    logic [1:0]  fin_status;

    always_comb begin
        state_d      = state_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        tcnt_d       = tcnt_q;
        rcnt_d       = rcnt_q;
        retry_d      = retry_q;
        req_ready_d  = req_ready_q;
        rsp_done_d   = 1'b0;
        rsp_status_d = rsp_status_q;
        rsp_rdata_d  = rsp_rdata_q;
        rqstn_d      = rqstn_q;
        startn_d     = startn_q;
        tm1n_d       = tm1n_q;
        tm0n_d       = tm0n_q;
        ad_d         = ad_q;
        oe_d         = oe_q;
        mstdn_d      = 1'b0;
        fin_status   = 2'b00;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    wr_d        = req_write;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    rcnt_d      = 4'd0;
                    req_ready_d = 1'b0;
                    rqstn_d     = 1'b0;
                    state_d     = S_ARB;
                end
            end
            S_ARB: begin
                if (arb_grant && nub_startn && nub_ackn) begin
                    rqstn_d  = 1'b1;
                    startn_d = 1'b0;
                    tm1n_d   = ~wr_q;
                    tm0n_d   = 1'b1;
                    ad_d     = {addr_q, 2'b00};
                    oe_d     = 1'b1;
                    tcnt_d   = 8'd0;
                    state_d  = S_ADDR;
                end
            end
            S_ADDR: begin
                startn_d = 1'b1;
                tm1n_d   = 1'b1;
                tm0n_d   = 1'b1;
                ad_d     = wr_q ? wdata_q : 32'd0;
                oe_d     = wr_q;
                state_d  = S_DATA;
            end
            S_DATA: begin
                if (tcnt_q == TLAST || !nub_ackn) begin
                    // Timeout wins over an ACK arriving in the final cycle.
                    fin_status = (tcnt_q == TLAST) ? 2'b10 : {~nub_tm1n, ~nub_tm0n};
                    ad_d       = 32'd0;
                    oe_d       = 1'b0;
                    retry_d    = (fin_status == 2'b11) && (rcnt_q < RMAX);
                    // The outcome is known here, so the response registers load on DONE entry.
                    if (!retry_d) begin
                        rsp_done_d   = 1'b1;
                        mstdn_d      = 1'b1;
                        rsp_status_d = fin_status;
                        if (!wr_q && fin_status == 2'b00)
                            rsp_rdata_d = nub_ad_i;
                    end
                    state_d = S_DONE;
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
            end
            S_DONE: begin
                if (retry_q) begin
                    rcnt_d  = rcnt_q + 4'd1;
                    rqstn_d = 1'b0;
                    state_d = S_ARB;
                end else begin
                    req_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge nub_clkn or posedge nub_reset) begin
        if (nub_reset) begin
            state_q      <= S_IDLE;
            wr_q         <= 1'b0;
            addr_q       <= 30'd0;
            wdata_q      <= 32'd0;
            tcnt_q       <= 8'd0;
            rcnt_q       <= 4'd0;
            retry_q      <= 1'b0;
            req_ready_q  <= 1'b1;
            rsp_done_q   <= 1'b0;
            rsp_status_q <= 2'b00;
            rsp_rdata_q  <= 32'd0;
            rqstn_q      <= 1'b1;
            startn_q     <= 1'b1;
            tm1n_q       <= 1'b1;
            tm0n_q       <= 1'b1;
            ad_q         <= 32'd0;
            oe_q         <= 1'b0;
            mstdn_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            tcnt_q       <= tcnt_d;
            rcnt_q       <= rcnt_d;
            retry_q      <= retry_d;
            req_ready_q  <= req_ready_d;
            rsp_done_q   <= rsp_done_d;
            rsp_status_q <= rsp_status_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rqstn_q      <= rqstn_d;
            startn_q     <= startn_d;
            tm1n_q       <= tm1n_d;
            tm0n_q       <= tm0n_d;
            ad_q         <= ad_d;
            oe_q         <= oe_d;
            mstdn_q      <= mstdn_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign rsp_done     = rsp_done_q;
    assign rsp_status   = rsp_status_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign nub_rqstn_o  = rqstn_q;
    assign nub_startn_o = startn_q;
    assign nub_tm1n_o   = tm1n_q;
    assign nub_tm0n_o   = tm0n_q;
    assign nub_ad_o     = ad_q;
    assign nub_ad_oe    = oe_q;
    assign mstdn        = mstdn_q;

endmodule

// File: tb/tb_nubus_master.sv
// Directed bench for nubus_master (TIMEOUT=4, RETRY_MAX=2); local side and bus driven cycle by cycle.
module tb_nubus_master;

    logic        nub_clkn = 1'b0;
    logic        nub_reset;
    logic        req_valid, req_ready, req_write;
    logic [29:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_done;
    logic [1:0]  rsp_status;
    logic [31:0] rsp_rdata;
    logic        arb_grant, nub_rqstn_o;
    logic        nub_startn, nub_ackn, nub_tm1n, nub_tm0n;
    logic        nub_startn_o, nub_tm1n_o, nub_tm0n_o;
    logic [31:0] nub_ad_i, nub_ad_o;
    logic        nub_ad_oe, mstdn;

    int n_checks = 0;
    int n_fail   = 0;
    int n_start  = 0;
    int n_done   = 0;
    int sb, db;
    bit got;

    always #5 nub_clkn = ~nub_clkn;

    nubus_master #(.TIMEOUT(4), .RETRY_MAX(2)) dut (
        .nub_clkn(nub_clkn), .nub_reset(nub_reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_done(rsp_done), .rsp_status(rsp_status), .rsp_rdata(rsp_rdata),
        .arb_grant(arb_grant), .nub_rqstn_o(nub_rqstn_o),
        .nub_startn(nub_startn), .nub_ackn(nub_ackn), .nub_tm1n(nub_tm1n), .nub_tm0n(nub_tm0n),
        .nub_startn_o(nub_startn_o), .nub_tm1n_o(nub_tm1n_o), .nub_tm0n_o(nub_tm0n_o),
        .nub_ad_i(nub_ad_i), .nub_ad_o(nub_ad_o), .nub_ad_oe(nub_ad_oe), .mstdn(mstdn)
    );

    // START cycles and rsp_done pulses, counted mid-cycle.
    always @(negedge nub_clkn) begin
        if (!nub_startn_o) n_start <= n_start + 1;
        if (rsp_done)      n_done  <= n_done + 1;
    end

    task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_checks++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got_v, exp_v);
        end
    endtask

    task automatic tick;
        @(posedge nub_clkn);
        #1;
    endtask

    task automatic req(input logic w, input logic [29:0] a, input logic [31:0] d);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        tick;
        req_valid = 1'b0;
    endtask

    // Slave model: ACK in the first DATA cycle of each attempt, TM levels taken from tms per attempt.
    task automatic drive_acks(input logic [5:0] tms, output bit got_done);
        int  att = 0;
        bit  prev_start = 1'b0;
        got_done = 1'b0;
        for (int i = 0; i < 80 && !got_done; i++) begin
            tick;
            if (rsp_done) got_done = 1'b1;
            if (prev_start && att < 3) begin
                nub_ackn = 1'b0;
                {nub_tm1n, nub_tm0n} = tms[2*att +: 2];
                att++;
            end else begin
                nub_ackn = 1'b1;
                nub_tm1n = 1'b1;
                nub_tm0n = 1'b1;
            end
            prev_start = !nub_startn_o;
        end
        nub_ackn = 1'b1;
        nub_tm1n = 1'b1;
        nub_tm0n = 1'b1;
    endtask

    initial begin
        nub_reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        arb_grant = 1'b0; nub_startn = 1'b1; nub_ackn = 1'b1;
        nub_tm1n = 1'b1; nub_tm0n = 1'b1; nub_ad_i = '0;
        repeat (2) tick;
        nub_reset = 1'b0;
        tick;
        check("rst_ready",  req_ready, 1);
        check("rst_done",   rsp_done, 0);
        check("rst_status", rsp_status, 0);
        check("rst_rdata",  rsp_rdata, 0);
        check("rst_rqstn",  nub_rqstn_o, 1);
        check("rst_startn", nub_startn_o, 1);
        check("rst_oe",     nub_ad_oe, 0);
        check("rst_mstdn",  mstdn, 0);

        // Read, ACK with TM=11 in the second DATA cycle
        arb_grant = 1'b1;
        req(1'b0, 30'h0100_0004, 32'h0);
        check("rd_arb_rqstn", nub_rqstn_o, 0);
        check("rd_arb_ready", req_ready, 0);
        tick;
        check("rd_addr_startn", nub_startn_o, 0);
        check("rd_addr_ad",     nub_ad_o, 32'h0400_0010);
        check("rd_addr_oe",     nub_ad_oe, 1);
        check("rd_addr_tm1n",   nub_tm1n_o, 1);
        check("rd_addr_tm0n",   nub_tm0n_o, 1);
        check("rd_addr_rqstn",  nub_rqstn_o, 1);
        tick;
        check("rd_data_startn", nub_startn_o, 1);
        check("rd_data_oe",     nub_ad_oe, 0);
        tick;
        nub_ackn = 1'b0; nub_tm1n = 1'b1; nub_tm0n = 1'b1; nub_ad_i = 32'hDEAD_BEEF;
        tick;
        check("rd_done",   rsp_done, 1);
        check("rd_status", rsp_status, 2'b00);
        check("rd_rdata",  rsp_rdata, 32'hDEAD_BEEF);
        check("rd_mstdn",  mstdn, 1);
        nub_ackn = 1'b1; nub_ad_i = '0;
        tick;
        check("rd_done_pulse",  rsp_done, 0);
        check("rd_mstdn_pulse", mstdn, 0);
        check("rd_ready_back",  req_ready, 1);

        // Write of 0x1234_5678, ACK with TM=10 -> error
        req(1'b1, 30'h0000_0100, 32'h1234_5678);
        tick;
        check("wr_addr_tm1n", nub_tm1n_o, 0);
        check("wr_addr_ad",   nub_ad_o, 32'h0000_0400);
        tick;
        check("wr_data_oe", nub_ad_oe, 1);
        check("wr_data_ad", nub_ad_o, 32'h1234_5678);
        tick;
        check("wr_data2_oe", nub_ad_oe, 1);
        nub_ackn = 1'b0; nub_tm1n = 1'b1; nub_tm0n = 1'b0;
        tick;
        check("wr_done",   rsp_done, 1);
        check("wr_status", rsp_status, 2'b01);
        check("wr_rdata",  rsp_rdata, 32'hDEAD_BEEF);
        check("wr_oe_off", nub_ad_oe, 0);
        nub_ackn = 1'b1; nub_tm0n = 1'b1;
        tick;

        // Timeout: four DATA cycles, ACK in the last one is ignored
        req(1'b0, 30'h0000_0003, 32'h0);
        tick;
        repeat (3) tick;
        check("to_early", rsp_done, 0);
        tick;
        check("to_early4", rsp_done, 0);
        nub_ackn = 1'b0; nub_ad_i = 32'h1111_1111;
        tick;
        check("to_done",   rsp_done, 1);
        check("to_status", rsp_status, 2'b10);
        check("to_rdata",  rsp_rdata, 32'hDEAD_BEEF);
        check("to_oe",     nub_ad_oe, 0);
        nub_ackn = 1'b1; nub_ad_i = '0;
        tick;
        check("to_ready",  req_ready, 1);
        check("to_oe_idle", nub_ad_oe, 0);

        // Retries exhausted: three try-again-later ACKs
        sb = n_start; db = n_done;
        nub_ad_i = 32'hCAFE_F00D;
        req(1'b0, 30'h0000_0010, 32'h0);
        drive_acks(6'b000000, got);
        check("rty_got_done", got, 1);
        tick;
        check("rty_starts", n_start - sb, 3);
        check("rty_dones",  n_done - db, 1);
        check("rty_status", rsp_status, 2'b11);
        check("rty_rdata",  rsp_rdata, 32'hDEAD_BEEF);
        check("rty_ready",  req_ready, 1);

        // One retry then success
        sb = n_start; db = n_done;
        req(1'b0, 30'h0000_0011, 32'h0);
        drive_acks(6'b001100, got);
        check("rty2_got_done", got, 1);
        tick;
        check("rty2_starts", n_start - sb, 2);
        check("rty2_dones",  n_done - db, 1);
        check("rty2_status", rsp_status, 2'b00);
        check("rty2_rdata",  rsp_rdata, 32'hCAFE_F00D);
        nub_ad_i = '0;

        // Arbitration: bus busy, then grant withdrawn, then idle + grant
        sb = n_start;
        nub_startn = 1'b0; arb_grant = 1'b1;
        req(1'b0, 30'h0000_0020, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick;
            check("arb_busy_rqstn", nub_rqstn_o, 0);
        end
        nub_startn = 1'b1; arb_grant = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick;
            check("arb_nogrant_rqstn", nub_rqstn_o, 0);
        end
        check("arb_no_start", n_start - sb, 0);
        arb_grant = 1'b1;
        tick;
        check("arb_start", nub_startn_o, 0);
        tick;
        nub_ackn = 1'b0; nub_tm1n = 1'b1; nub_tm0n = 1'b1;
        tick;
        check("arb_done",   rsp_done, 1);
        check("arb_status", rsp_status, 2'b00);
        nub_ackn = 1'b1;
        tick;

        // Reset asserted mid-DATA
        db = n_done;
        req(1'b1, 30'h0000_0055, 32'hA5A5_5A5A);
        tick;
        tick;
        check("mrst_pre_oe", nub_ad_oe, 1);
        #2 nub_reset = 1'b1;
        #1;
        check("mrst_oe",     nub_ad_oe, 0);
        check("mrst_ad",     nub_ad_o, 0);
        check("mrst_rqstn",  nub_rqstn_o, 1);
        check("mrst_startn", nub_startn_o, 1);
        check("mrst_tm1n",   nub_tm1n_o, 1);
        check("mrst_ready",  req_ready, 1);
        check("mrst_done",   rsp_done, 0);
        check("mrst_rdata",  rsp_rdata, 0);
        check("mrst_mstdn",  mstdn, 0);
        tick;
        nub_reset = 1'b0;
        repeat (3) tick;
        check("mrst_no_done", n_done - db, 0);
        check("mrst_ready_after", req_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
